store_monitor: RTL
==================

# store_monitor

Synthesizable store-stream checker sitting directly downstream of the processor's data-memory write port. Samples MemWrite/DataAdr/WriteData every cycle, declares pass on the terminating store (default: 7 to address 0x64), fail on any store outside the allowed address set, or timeout if the program never terminates. Gives the same verdict as the simulation checker, but as hardware usable on the FPGA build (LEDs/ILA). An optional FIFO logs every observed store for later readout.

## Interface
- PASS_ADDR, 32'd100, address of the terminating store
- PASS_DATA, 32'd7, data required at PASS_ADDR
- ALLOW_ADDR, 32'd96, only non-terminating address permitted
- TIMEOUT_CYCLES, 1000, RUN cycles before timeout; must be ≥ 2
- LOG_DEPTH, 8, store log entries; power of two, ≥ 2
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- MemWrite  in  1  store strobe from processor
- DataAdr  in  32  store address
- WriteData  in  32  store data
- done  out  1  verdict reached (pass|fail|timeout)
- pass  out  1  terminating store seen
- fail  out  1  illegal store seen
- timeout  out  1  TIMEOUT_CYCLES elapsed with no verdict
- write_count  out  16  stores seen in RUN, saturating at 16'hFFFF
- cycle_count  out  32  RUN cycles elapsed; frozen at verdict
- fail_addr  out  32  DataAdr of the failing store
- fail_data  out  32  WriteData of the failing store
- log_rd  in  1  pop one log entry
- log_valid  out  1  log non-empty
- log_addr  out  32  head-entry address (show-ahead)
- log_data  out  32  head-entry data (show-ahead)
- log_overflow  out  1  sticky; a store was dropped because the log was full

## Operation
- States: RUN, PASS, FAIL, TIMEOUT. Reset → RUN. PASS/FAIL/TIMEOUT are sticky until reset.
- In RUN, each edge with MemWrite=1, priority order:
  - DataAdr==PASS_ADDR && WriteData==PASS_DATA → PASS
  - else DataAdr!=ALLOW_ADDR → FAIL; capture fail_addr/fail_data
  - else stay in RUN
- Every store in RUN (terminating one included) increments write_count and pushes {DataAdr, WriteData} into the log.
- cycle_count increments on every RUN edge. When it would reach TIMEOUT_CYCLES and no store verdict occurs on that edge → TIMEOUT. A store verdict on the same edge wins over timeout.
- Stores outside RUN are ignored: no count, no log push.
- Address/data comparisons are full 32-bit equality; X/Z is not handled in RTL.
- Log: push when not full. Push when full → drop the entry and set log_overflow. Simultaneous push and pop while full → both occur, no overflow. log_rd while empty is ignored. Log reads remain allowed in every state.
- Reset values: all outputs 0; fail_addr/fail_data 0; log empty.

## Timing
- Inputs are sampled on the rising edge; all outputs are registered.
- Verdict latency: a store sampled at edge N shows done/pass/fail after edge N. Likewise, write_count and log_valid update after edge N.
- done = pass|fail|timeout, each one-hot. At most one of them is ever high.
- Timeout asserts after edge TIMEOUT_CYCLES counted from the first edge with reset=0. cycle_count then reads TIMEOUT_CYCLES.
- log_rd at edge N: the next entry is presented after edge N.
- Reset asserted mid-run clears everything at that edge; monitoring restarts on the first edge with reset low.

## Configuration
- STORE_MONITOR_LOG_EN defined: log FIFO is instantiated and behaves as described above.
- Not defined: no FIFO storage. log_valid, log_addr, log_data and log_overflow are tied to 0, and log_rd is ignored. Port list is unchanged. Verdict, counters and fail capture are unaffected.

## Structure
- Package store_monitor_pkg holds:
  - the state enum (MON_RUN, MON_PASS, MON_FAIL, MON_TIMEOUT)
  - the default address/data constants
  - the log entry struct {addr[31:0], data[31:0]}
- One sub-module: store_log_fifo. It is a synchronous show-ahead FIFO (push/pop/full/empty), parameterised by depth, and is instantiated only under STORE_MONITOR_LOG_EN.

## Test plan
- **Pass run:** store 96←3, then 100←7 → pass=1 and done=1 one cycle after the second store; write_count=2; fail=0; log pops (96,3) then (100,7).
- **Bad address:** store 200←5 → fail=1, fail_addr=200, fail_data=5. A later store 100←7 leaves pass=0 and write_count=1.
- **Wrong data:** store 100←8 → fail=1, fail_addr=100, fail_data=8.
- **Timeout:** TIMEOUT_CYCLES=50, no stores → timeout=1 after edge 50, cycle_count=50. Then store 100←7 on edge 50 in a rerun → pass=1, timeout=0.
- **Log overflow:** LOG_DEPTH=4, five stores 96←1..5 → log_overflow=1; log pops return 1,2,3,4, then log_valid=0.
- **Mid-run reset:** after two stores to 96, assert reset for one edge → write_count=0, log empty, state RUN. A subsequent 100←7 → pass=1.

Source files
------------

// File: rtl/store_monitor_pkg.sv
// Shared types and defaults for the store-stream monitor.
package store_monitor_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  // Default terminating store and the single permitted scratch address
  localparam logic [ADDR_W-1:0] DEF_PASS_ADDR  = 32'd100;
  localparam logic [DATA_W-1:0] DEF_PASS_DATA  = 32'd7;
  localparam logic [ADDR_W-1:0] DEF_ALLOW_ADDR = 32'd96;

  typedef enum logic [1:0] {
    MON_RUN     = 2'd0,
    MON_PASS    = 2'd1,
    MON_FAIL    = 2'd2,
    MON_TIMEOUT = 2'd3
  } mon_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } log_entry_t;

  // Saturating increment for the store counter
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/store_log_fifo.sv
// Synchronous show-ahead FIFO holding observed stores.
// Push while full is dropped (drop_o pulses) unless a pop frees a slot on the same edge.
module store_log_fifo
  import store_monitor_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  log_entry_t entry_i,
  input  logic       pop_i,
  output log_entry_t head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  log_entry_t      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic            push_ok_c;
  logic            pop_ok_c;

  // Extra pointer MSB distinguishes full from empty
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok_c  = pop_i && !empty_o;
  assign push_ok_c = push_i && (!full_o || pop_ok_c);
  assign drop_o    = push_i && !push_ok_c;
  assign head_o    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Entry storage; contents are only observed through valid pointers
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
  end

endmodule

// File: rtl/store_monitor.sv
// Store-stream checker: pass on the terminating store, fail on a store to an
// illegal address, timeout if no verdict arrives in time.
// Optional store log FIFO enabled by defining STORE_MONITOR_LOG_EN.
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PASS_ADDR      = DEF_PASS_ADDR,
  parameter logic [DATA_W-1:0] PASS_DATA      = DEF_PASS_DATA,
  parameter logic [ADDR_W-1:0] ALLOW_ADDR     = DEF_ALLOW_ADDR,
  parameter int unsigned       TIMEOUT_CYCLES = 1000,
  parameter int unsigned       LOG_DEPTH      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  write_count,
  output logic [31:0]       cycle_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  input  logic              log_rd,
  output logic              log_valid,
  output logic [ADDR_W-1:0] log_addr,
  output logic [DATA_W-1:0] log_data,
  output logic              log_overflow
);

  mon_state_e        state_q;
  logic              done_q, pass_q, fail_q, timeout_q;
  logic [CNT_W-1:0]  write_count_q, write_count_d;
  logic [31:0]       cycle_count_q, cycle_count_d;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;

  logic in_run_c, store_c, pass_hit_c, fail_hit_c, tmo_hit_c;

  // Verdict decode for the current edge; store verdicts outrank timeout
  assign in_run_c      = (state_q == MON_RUN);
  assign store_c       = in_run_c && MemWrite;
  assign pass_hit_c    = store_c && (DataAdr == PASS_ADDR) && (WriteData == PASS_DATA);
  assign fail_hit_c    = store_c && !pass_hit_c && (DataAdr != ALLOW_ADDR);
  assign cycle_count_d = cycle_count_q + 32'd1;
  assign tmo_hit_c     = in_run_c && !pass_hit_c && !fail_hit_c &&
                         (cycle_count_d == 32'(TIMEOUT_CYCLES));
  assign write_count_d = sat_inc(write_count_q);

  // Monitor FSM with registered verdict flags, counters and fail capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= MON_RUN;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
      write_count_q <= '0;
      cycle_count_q <= '0;
      fail_addr_q   <= '0;
      fail_data_q   <= '0;
    end else begin
      case (state_q)
        MON_RUN: begin
          cycle_count_q <= cycle_count_d;
          if (store_c) write_count_q <= write_count_d;
          if (pass_hit_c) begin
            state_q <= MON_PASS;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else if (fail_hit_c) begin
            state_q     <= MON_FAIL;
            done_q      <= 1'b1;
            fail_q      <= 1'b1;
            fail_addr_q <= DataAdr;
            fail_data_q <= WriteData;
          end else if (tmo_hit_c) begin
            state_q   <= MON_TIMEOUT;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign write_count = write_count_q;
  assign cycle_count = cycle_count_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;

`ifdef STORE_MONITOR_LOG_EN
  log_entry_t log_in_c;
  log_entry_t log_head_c;
  logic       log_full_c, log_empty_c, log_drop_c;
  logic       log_overflow_q;

  assign log_in_c = '{addr: DataAdr, data: WriteData};

  store_log_fifo #(
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk     (clk),
    .reset   (reset),
    .push_i  (store_c),
    .entry_i (log_in_c),
    .pop_i   (log_rd),
    .head_o  (log_head_c),
    .full_o  (log_full_c),
    .empty_o (log_empty_c),
    .drop_o  (log_drop_c)
  );

  // Sticky record of any store dropped on a full log
  always_ff @(posedge clk) begin
    if (reset)           log_overflow_q <= 1'b0;
    else if (log_drop_c) log_overflow_q <= 1'b1;
  end

  // Head is masked while empty so stale storage never leaks out
  assign log_valid    = !log_empty_c;
  assign log_addr     = log_empty_c ? '0 : log_head_c.addr;
  assign log_data     = log_empty_c ? '0 : log_head_c.data;
  assign log_overflow = log_overflow_q;
  logic unused_full_c;
  assign unused_full_c = log_full_c;
`else
  // No log storage: readout ports are constant and log_rd has no effect
  logic unused_log_c;
  assign unused_log_c = log_rd ^ (LOG_DEPTH == 0);
  assign log_valid    = 1'b0;
  assign log_addr     = '0;
  assign log_data     = '0;
  assign log_overflow = 1'b0;
`endif

endmodule
